// File: rtl/arbitro_logica4.sv
// Round-robin arbiter sharing one 4-bit logic unit between two requesters.
// Define LOGIC4_XOR_EN to enable opcode 10 (A XOR B); otherwise it is illegal.

module logic4_and (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module logic4_or (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module logic4_unit (
    input  logic [1:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y,
    output logic       illegal
);
    logic [3:0] and_ab;
    logic [3:0] or_ab;
`ifdef LOGIC4_XOR_EN
    logic [3:0] xor_ab;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_bit
        logic4_and u_and (
            .a (a[i]),
            .b (b[i]),
            .y (and_ab[i])
        );
        logic4_or u_or (
            .a (a[i]),
            .b (b[i]),
            .y (or_ab[i])
        );
`ifdef LOGIC4_XOR_EN
        // XOR as (A|B) & ~(A&B), reusing the gate cells
        logic4_and u_xor (
            .a (or_ab[i]),
            .b (~and_ab[i]),
            .y (xor_ab[i])
        );
`endif
    end

    always_comb begin
        y       = 4'b0000;
        illegal = 1'b0;
        unique case (op)
            2'b00: y = and_ab;
            2'b01: y = or_ab;
            2'b10: begin
`ifdef LOGIC4_XOR_EN
                y = xor_ab;
`else
                illegal = 1'b1;
`endif
            end
            2'b11: y = ~a;
            default: y = 4'b0000;
        endcase
    end
endmodule

module arbitro_logica4 #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [1:0] op0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [1:0] op1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic [3:0] S,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(EXEC_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [1:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       idx;
    logic       ultimo;
    logic [2:0] cnt;

    logic       grant;
    logic       grant_idx;
    logic [3:0] unit_y;
    logic       unit_illegal;

    logic4_unit u_unit (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .y       (unit_y),
        .illegal (unit_illegal)
    );

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_idx  = 1'b0;
        unique case (state)
            IDLE: begin
                // on a tie the requester not served last wins
                if (req0 && req1) begin
                    grant     = 1'b1;
                    grant_idx = ~ultimo;
                end else if (req0) begin
                    grant     = 1'b1;
                    grant_idx = 1'b0;
                end else if (req1) begin
                    grant     = 1'b1;
                    grant_idx = 1'b1;
                end
                if (grant) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 3'd0) begin
                    next_state = DONE;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= 2'b00;
            a_q    <= 4'b0000;
            b_q    <= 4'b0000;
            idx    <= 1'b0;
            ultimo <= 1'b1;
            cnt    <= 3'd0;
            S      <= 4'b0000;
            err    <= 1'b0;
        end else begin
            state <= next_state;
            if (grant) begin
                op_q <= grant_idx ? op1 : op0;
                a_q  <= grant_idx ? a1 : a0;
                b_q  <= grant_idx ? b1 : b0;
                idx  <= grant_idx;
                cnt  <= CNT_LOAD;
            end
            if (state == EXEC) begin
                if (cnt != 3'd0) begin
                    cnt <= cnt - 3'd1;
                end else begin
                    S   <= unit_y;
                    err <= unit_illegal;
                end
            end
            if (state == DONE) begin
                ultimo <= idx;
            end
        end
    end

    assign done0 = (state == DONE) && !idx;
    assign done1 = (state == DONE) && idx;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_arbitro_logica4.sv
// Directed bench for arbitro_logica4: one instance with EXEC_CYCLES=1, one with 3.
// Expectations for opcode 10 follow LOGIC4_XOR_EN.

module tb_arbitro_logica4;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0;
    logic       req1;
    logic [1:0] op0;
    logic [1:0] op1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;

    logic [3:0] s_a;
    logic       done0_a;
    logic       done1_a;
    logic       err_a;
    logic       busy_a;
    logic [3:0] s_b;
    logic       done0_b;
    logic       done1_b;
    logic       err_b;
    logic       busy_b;

    int checks = 0;
    int errors = 0;
    int w;
    int c;
    logic seen;

    always #5 clk = ~clk;

    arbitro_logica4 #(.EXEC_CYCLES(1)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .op0   (op0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .op1   (op1),
        .a1    (a1),
        .b1    (b1),
        .S     (s_a),
        .done0 (done0_a),
        .done1 (done1_a),
        .err   (err_a),
        .busy  (busy_a)
    );

    arbitro_logica4 #(.EXEC_CYCLES(3)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .op0   (op0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .op1   (op1),
        .a1    (a1),
        .b1    (b1),
        .S     (s_b),
        .done0 (done0_b),
        .done1 (done1_b),
        .err   (err_b),
        .busy  (busy_b)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // waits for a done pulse on instance d (0=a, 1=b); which=2 flags both
    task automatic wait_done(input int d, output int which, output int cyc);
        logic d0;
        logic d1;
        which = -1;
        cyc   = 0;
        for (int i = 0; i < 20 && which < 0; i++) begin
            @(negedge clk);
            cyc++;
            d0 = d != 0 ? done0_b : done0_a;
            d1 = d != 0 ? done1_b : done1_a;
            if (d0 && d1) which = 2;
            else if (d0) which = 0;
            else if (d1) which = 1;
        end
        check("done_seen", {7'b0, which >= 0}, 8'd1);
    endtask

    initial begin
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        op0   = 2'b00;
        op1   = 2'b00;
        a0    = 4'h0;
        b0    = 4'h0;
        a1    = 4'h0;
        b1    = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_s_a", {4'h0, s_a}, 8'h00);
        check("rst_flags_a", {4'h0, done0_a, done1_a, err_a, busy_a}, 8'h00);
        check("rst_s_b", {4'h0, s_b}, 8'h00);
        check("rst_flags_b", {4'h0, done0_b, done1_b, err_b, busy_b}, 8'h00);
        reset = 1'b0;

        // single request, OR
        req0 = 1'b1; op0 = 2'b01; a0 = 4'b1010; b0 = 4'b0101;
        @(negedge clk);
        check("single_busy", {7'b0, busy_a}, 8'd1);
        check("single_early_done", {7'b0, done0_a}, 8'd0);
        wait_done(0, w, c);
        check("single_which", 8'(w), 8'd0);
        check("single_lat", 8'(c), 8'd1);
        check("single_s", {4'h0, s_a}, 8'h0f);
        check("single_err", {7'b0, err_a}, 8'd0);
        req0 = 1'b0;
        @(negedge clk);
        check("single_idle", {6'b0, busy_a, done0_a}, 8'd0);
        check("single_hold", {4'h0, s_a}, 8'h0f);
        repeat (8) @(negedge clk);

        // tie and fairness: 0 does AND, 1 does NOT
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b1; op0 = 2'b00; a0 = 4'b1100; b0 = 4'b1010;
        req1 = 1'b1; op1 = 2'b11; a1 = 4'b0101; b1 = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wait_done(0, w, c);
            check("tie_which", 8'(w), 8'(i % 2));
            check("tie_lat", 8'(c), (i == 0) ? 8'd2 : 8'd3);
            check("tie_s", {4'h0, s_a}, (i % 2 == 0) ? 8'h08 : 8'h0a);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (10) @(negedge clk);

        // operands change and req drops during EXEC on the 3-cycle instance
        req0 = 1'b1; op0 = 2'b00; a0 = 4'b1111; b0 = 4'b0110;
        @(negedge clk);
        a0 = 4'b0000; op0 = 2'b01; b0 = 4'b1001; req0 = 1'b0;
        wait_done(1, w, c);
        check("latch_which", 8'(w), 8'd0);
        check("latch_lat", 8'(c), 8'd3);
        check("latch_s", {4'h0, s_b}, 8'h06);
        @(negedge clk);
        check("latch_idle", {7'b0, busy_b}, 8'd0);

        // reset in the middle of EXEC
        req1 = 1'b1; op1 = 2'b00; a1 = 4'b1111; b1 = 4'b0101;
        repeat (2) @(negedge clk);
        check("mid_busy", {7'b0, busy_b}, 8'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {7'b0, busy_b}, 8'd0);
        check("mid_rst_s", {4'h0, s_b}, 8'h00);
        check("mid_rst_done", {6'b0, done0_b, done1_b}, 8'd0);
        req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | done0_b | done1_b;
        end
        check("mid_no_done", {7'b0, seen}, 8'd0);

        // tie after reset: 0 wins with NOT, then 1 with OR
        req0 = 1'b1; op0 = 2'b11; a0 = 4'b0011; b0 = 4'b1111;
        req1 = 1'b1; op1 = 2'b01; a1 = 4'b1000; b1 = 4'b0001;
        wait_done(1, w, c);
        check("not_which", 8'(w), 8'd0);
        check("not_lat", 8'(c), 8'd4);
        check("not_s", {4'h0, s_b}, 8'h0c);
        req0 = 1'b0;
        wait_done(1, w, c);
        check("pend_which", 8'(w), 8'd1);
        check("pend_lat", 8'(c), 8'd5);
        check("pend_s", {4'h0, s_b}, 8'h09);
        req1 = 1'b0;
        repeat (10) @(negedge clk);

        // opcode 10 on requester 1
        req1 = 1'b1; op1 = 2'b10; a1 = 4'b1100; b1 = 4'b1010;
        wait_done(0, w, c);
        check("xor_which", 8'(w), 8'd1);
        check("xor_lat", 8'(c), 8'd2);
`ifdef LOGIC4_XOR_EN
        check("xor_s", {4'h0, s_a}, 8'h06);
        check("xor_err", {7'b0, err_a}, 8'd0);
`else
        check("xor_s", {4'h0, s_a}, 8'h00);
        check("xor_err", {7'b0, err_a}, 8'd1);
`endif
        req1 = 1'b0;

        // a legal op afterwards clears err
        req0 = 1'b1; op0 = 2'b01; a0 = 4'b0001; b0 = 4'b0010;
        wait_done(0, w, c);
        check("clr_which", 8'(w), 8'd0);
        check("clr_s", {4'h0, s_a}, 8'h03);
        check("clr_err", {7'b0, err_a}, 8'd0);
        req0 = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
